// File: rtl/operand_stream_buffer.sv
// operand_stream_buffer
//   Decoupling stage between two operand streams (a, b) and a two-input,
//   one-result arithmetic unit, all channels using stb/ack handshakes.
//   Operands are paired, queued (DEPTH pairs), issued to the unit one pair at
//   a time, and results are queued (DEPTH entries) for the downstream consumer.
//   An issue credit is spent per pair popped and returned per result leaving,
//   so a result slot is always reserved and the unit never stalls on output.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   input_a/_stb/_ack        operand a stream in
//   input_b/_stb/_ack        operand b stream in
//   unit_a/_stb/_ack         operand a to unit
//   unit_b/_stb/_ack         operand b to unit
//   unit_z/_stb/_ack         result from unit
//   output_z/_stb/_ack       buffered result out
//
// Optional build macro STREAM_STATS_EN adds:
//   issued_count[31:0]       wrapping count of pairs popped for issue
//   retired_count[31:0]      wrapping count of results delivered downstream
//   overrun                  sticky: unit_z_stb seen while result queue full

// Circular FIFO with one extra pointer bit to tell full from empty.
// Push is ignored when full and pop when empty.
module osb_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                  wr_ptr, rd_ptr;
    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic                         push_ok, pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage is cleared too so the head reads 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

module operand_stream_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
    input  logic             input_a_stb,
    output logic             input_a_ack,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_b_stb,
    output logic             input_b_ack,
    output logic [WIDTH-1:0] unit_a,
    output logic             unit_a_stb,
    input  logic             unit_a_ack,
    output logic [WIDTH-1:0] unit_b,
    output logic             unit_b_stb,
    input  logic             unit_b_ack,
    input  logic [WIDTH-1:0] unit_z,
    input  logic             unit_z_stb,
    output logic             unit_z_ack,
    output logic [WIDTH-1:0] output_z,
    output logic             output_z_stb,
    input  logic             output_z_ack
`ifdef STREAM_STATS_EN
    ,
    output logic [31:0]      issued_count,
    output logic [31:0]      retired_count,
    output logic             overrun
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     a_hold, b_hold;
    logic                 a_valid, b_valid;
    logic                 a_xfer, b_xfer;
    pair_t                pair_in, pair_head;
    logic [2*WIDTH-1:0]   pair_dout;
    logic                 pair_push, pair_pop, pair_full, pair_empty;
    logic                 res_push, res_pop, res_full, res_empty;
    logic [CW-1:0]        credits;
    logic                 ua_stb_nx, ub_stb_nx;

    // Handshake acks are forced low while reset is held.
    assign input_a_ack  = !a_valid && !rst;
    assign input_b_ack  = !b_valid && !rst;
    assign unit_z_ack   = !res_full && !rst;
    assign output_z_stb = !res_empty;

    assign a_xfer    = input_a_stb && input_a_ack;
    assign b_xfer    = input_b_stb && input_b_ack;
    assign pair_push = a_valid && b_valid && !pair_full;
    assign pair_in   = '{a: a_hold, b: b_hold};
    assign pair_head = pair_dout;
    assign res_push  = unit_z_stb && unit_z_ack;
    assign res_pop   = output_z_stb && output_z_ack;

    // Operand capture: one word per side until the pair is pushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_hold  <= '0;
            b_hold  <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            if (a_xfer) begin
                a_hold  <= input_a;
                a_valid <= 1'b1;
            end else if (pair_push) begin
                a_valid <= 1'b0;
            end
            if (b_xfer) begin
                b_hold  <= input_b;
                b_valid <= 1'b1;
            end else if (pair_push) begin
                b_valid <= 1'b0;
            end
        end
    end

    osb_fifo #(.WIDTH(2*WIDTH), .DEPTH(DEPTH)) u_pair_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pair_push),
        .din   (pair_in),
        .pop   (pair_pop),
        .dout  (pair_dout),
        .full  (pair_full),
        .empty (pair_empty)
    );

    osb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_push),
        .din   (unit_z),
        .pop   (res_pop),
        .dout  (output_z),
        .full  (res_full),
        .empty (res_empty)
    );

    // Issue FSM: a pop needs a queued pair and a reserved result slot.
    // The two unit strobes retire independently; IDLE only once both are taken.
    always_comb begin
        state_nx  = state;
        pair_pop  = 1'b0;
        ua_stb_nx = unit_a_stb;
        ub_stb_nx = unit_b_stb;
        case (state)
            IDLE: begin
                if (!pair_empty && (credits != '0)) begin
                    pair_pop  = 1'b1;
                    ua_stb_nx = 1'b1;
                    ub_stb_nx = 1'b1;
                    state_nx  = ISSUE;
                end
            end
            ISSUE: begin
                if (unit_a_ack) ua_stb_nx = 1'b0;
                if (unit_b_ack) ub_stb_nx = 1'b0;
                if (!ua_stb_nx && !ub_stb_nx) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            unit_a_stb <= 1'b0;
            unit_b_stb <= 1'b0;
            unit_a     <= '0;
            unit_b     <= '0;
        end else begin
            state      <= state_nx;
            unit_a_stb <= ua_stb_nx;
            unit_b_stb <= ub_stb_nx;
            if (pair_pop) begin
                unit_a <= pair_head.a;
                unit_b <= pair_head.b;
            end
        end
    end

    // Credits: spent on issue, returned when a result leaves; both at once cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CW'(DEPTH);
        end else begin
            case ({pair_pop, res_pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

`ifdef STREAM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_count  <= '0;
            retired_count <= '0;
            overrun       <= 1'b0;
        end else begin
            if (pair_pop)             issued_count  <= issued_count + 32'd1;
            if (res_pop)              retired_count <= retired_count + 32'd1;
            if (unit_z_stb && res_full) overrun     <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_stream_buffer.sv
module tb_operand_stream_buffer;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] input_a = '0, input_b = '0, unit_z = '0;
    logic             input_a_stb = 1'b0, input_b_stb = 1'b0;
    logic             unit_a_ack = 1'b0, unit_b_ack = 1'b0;
    logic             unit_z_stb = 1'b0, output_z_ack = 1'b0;
    logic             input_a_ack, input_b_ack, unit_a_stb, unit_b_stb;
    logic             unit_z_ack, output_z_stb;
    logic [WIDTH-1:0] unit_a, unit_b, output_z;
`ifdef STREAM_STATS_EN
    logic [31:0]      issued_count, retired_count;
    logic             overrun;
`endif

    always #5 clk = ~clk;

    operand_stream_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .unit_a       (unit_a),
        .unit_a_stb   (unit_a_stb),
        .unit_a_ack   (unit_a_ack),
        .unit_b       (unit_b),
        .unit_b_stb   (unit_b_stb),
        .unit_b_ack   (unit_b_ack),
        .unit_z       (unit_z),
        .unit_z_stb   (unit_z_stb),
        .unit_z_ack   (unit_z_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
`ifdef STREAM_STATS_EN
        ,
        .issued_count (issued_count),
        .retired_count(retired_count),
        .overrun      (overrun)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: streams in order, paired by position, unit in order,
    // results leave in issue order; nres = results held inside the buffer.
    logic [WIDTH-1:0] qa[$], qb[$], ua[$], ub[$], uz[$], expz[$];
    int nres = 0, n_issue = 0, n_retire = 0, n_acc_a = 0;
    int in_mode = 0, ack_mode = 0, z_mode = 0, out_mode = 0;  // 0 manual, 1 always, 2 random
    bit last_ax = 1'b0, last_bx = 1'b0;

    function automatic logic [WIDTH-1:0] op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    task automatic model_clear();
        qa.delete(); qb.delete(); ua.delete(); ub.delete(); uz.delete(); expz.delete();
        nres = 0; n_issue = 0; n_retire = 0; n_acc_a = 0;
        last_ax = 1'b0; last_bx = 1'b0;
    endtask

    task automatic step();
        bit ax, bx, uax, ubx, zx, ox;
        logic [WIDTH-1:0] sa, sb, soz;
        if (in_mode != 0) begin
            if (!input_a_stb || last_ax) begin
                input_a_stb = (in_mode == 1) || ($urandom_range(1) == 1);
                input_a     = WIDTH'($urandom);
            end
            if (!input_b_stb || last_bx) begin
                input_b_stb = (in_mode == 1) || ($urandom_range(1) == 1);
                input_b     = WIDTH'($urandom);
            end
        end
        if (ack_mode != 0) begin
            unit_a_ack = (ack_mode == 1) || ($urandom_range(1) == 1);
            unit_b_ack = (ack_mode == 1) || ($urandom_range(1) == 1);
        end
        if (z_mode != 0) begin
            unit_z_stb = (uz.size() > 0) && ((z_mode == 1) || ($urandom_range(1) == 1));
            unit_z     = (uz.size() > 0) ? uz[0] : '0;
        end
        if (out_mode != 0)
            output_z_ack = (out_mode == 1) || ($urandom_range(1) == 1);
        @(negedge clk);
        ax  = input_a_stb && input_a_ack;
        bx  = input_b_stb && input_b_ack;
        uax = unit_a_stb && unit_a_ack;
        ubx = unit_b_stb && unit_b_ack;
        zx  = unit_z_stb && unit_z_ack;
        ox  = output_z_stb && output_z_ack;
        sa = input_a; sb = input_b; soz = output_z;
        chk("out_stb", output_z_stb, nres > 0);
        if (unit_z_stb) chk("z_ack", unit_z_ack, 1);
        if (uax) begin
            chk("ua_pending", qa.size() > 0, 1);
            if (qa.size() > 0) begin
                chk("ua_data", unit_a, qa[0]);
                ua.push_back(qa.pop_front());
            end
            n_issue++;
        end
        if (ubx) begin
            chk("ub_pending", qb.size() > 0, 1);
            if (qb.size() > 0) begin
                chk("ub_data", unit_b, qb[0]);
                ub.push_back(qb.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (ax) begin qa.push_back(sa); n_acc_a++; end
        if (bx) qb.push_back(sb);
        last_ax = ax; last_bx = bx;
        if (zx) begin
            void'(uz.pop_front());
            nres++;
        end
        if (ox) begin
            chk("out_pending", expz.size() > 0, 1);
            if (expz.size() > 0) chk("out_data", soz, expz.pop_front());
            nres--;
            n_retire++;
        end
        while (ua.size() > 0 && ub.size() > 0) begin
            logic [WIDTH-1:0] v;
            v = op(ua.pop_front(), ub.pop_front());
            uz.push_back(v);
            expz.push_back(v);
        end
    endtask

    initial begin
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hs", {input_a_ack, input_b_ack, unit_a_stb, unit_b_stb, unit_z_ack, output_z_stb}, 0);
        chk("rst_data", {unit_a, unit_b}, 0);
        chk("rst_outz", output_z, 0);
        rst = 1'b0;
        #1;
        chk("rel_acks", {input_a_ack, input_b_ack, unit_z_ack}, 3'b111);

        // single op: a at edge 0, b at edge 3, unit strobes after edge 5
        input_a = 16'h4000; input_a_stb = 1'b1;
        step();
        input_a_stb = 1'b0;
        step(); step();
        chk("a_wait", input_a_ack, 0);
        input_b = 16'h3C00; input_b_stb = 1'b1;
        step();
        input_b_stb = 1'b0;
        chk("lat_e3", unit_a_stb, 0);
        step();
        chk("lat_e4", unit_a_stb, 0);
        step();
        chk("lat_e5", {unit_a_stb, unit_b_stb}, 2'b11);
        chk("op_a", unit_a, 16'h4000);
        chk("op_b", unit_b, 16'h3C00);

        // split acks: a at cycle 2, b at cycle 6, next pop at 7
        input_a = 16'h1111; input_b = 16'h2222; input_a_stb = 1'b1; input_b_stb = 1'b1;
        step();
        input_a_stb = 1'b0; input_b_stb = 1'b0;
        unit_a_ack = 1'b1;
        step();
        unit_a_ack = 1'b0;
        chk("split_a_drop", {unit_a_stb, unit_b_stb}, 2'b01);
        for (int k = 3; k <= 5; k++) begin
            step();
            chk("split_b_hold", {unit_a_stb, unit_b_stb}, 2'b01);
        end
        unit_b_ack = 1'b1;
        step();
        unit_b_ack = 1'b0;
        chk("split_idle", {unit_a_stb, unit_b_stb}, 0);
        step();
        chk("next_pop", {unit_a_stb, unit_b_stb}, 2'b11);
        chk("next_a", unit_a, 16'h1111);
        chk("next_b", unit_b, 16'h2222);

        ack_mode = 1; z_mode = 1; out_mode = 1;
        repeat (10) step();
        chk("drain1_n", n_retire, 2);
        chk("drain1_stb", output_z_stb, 0);

        // reset in the middle of an issue
        ack_mode = 0; unit_a_ack = 1'b0; unit_b_ack = 1'b0;
        input_a = 16'h0101; input_b = 16'h0202; input_a_stb = 1'b1; input_b_stb = 1'b1;
        step();
        input_a_stb = 1'b0; input_b_stb = 1'b0;
        step(); step();
        chk("pre_rst_stb", unit_a_stb, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid", {input_a_ack, input_b_ack, unit_a_stb, unit_b_stb, unit_z_ack, output_z_stb}, 0);
        model_clear();
        unit_z_stb = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // backpressure: downstream stalled, only DEPTH ops may issue
        out_mode = 0; output_z_ack = 1'b0;
        ack_mode = 1; z_mode = 1; in_mode = 1;
        repeat (40) step();
        chk("bp_issued", n_issue, DEPTH);
        chk("bp_acc_a", n_acc_a, 2 * DEPTH + 1);
        chk("bp_stall", {input_a_ack, input_b_ack}, 0);
        chk("bp_no_issue", unit_a_stb, 0);
        chk("bp_outstb", output_z_stb, 1);

        // drain in order
        in_mode = 0; input_a_stb = 1'b0; input_b_stb = 1'b0;
        out_mode = 1;
        repeat (40) step();
        chk("drain_n", n_retire, 2 * DEPTH + 1);
        chk("drain_empty", output_z_stb, 0);

        // randomized traffic on every channel
        in_mode = 2; ack_mode = 2; z_mode = 2; out_mode = 2;
        repeat (3000) step();
        in_mode = 0; input_a_stb = 1'b0; input_b_stb = 1'b0;
        ack_mode = 1; z_mode = 1; out_mode = 1;
        repeat (80) step();
        chk("final_issue", n_issue, n_acc_a);
        chk("final_retire", n_retire, n_issue);
        chk("final_empty", output_z_stb, 0);
`ifdef STREAM_STATS_EN
        chk("issued_cnt", issued_count, n_issue);
        chk("retired_cnt", retired_count, n_retire);
        chk("overrun", overrun, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
